// File: rtl/dot_addr_seq.sv
// dot_addr_seq: address sequencer for one dot product of the matrix-multiply
// datapath. Walks a row of A (stride 1) and a column of B (stride K) and
// issues one (addr_a, addr_b) pair per accepted valid/ready handshake.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high; returns to IDLE with outputs cleared
//   start       begin a sequence (only honoured in IDLE)
//   base_a      first A element address, captured with start
//   base_b      first B element address, captured with start
//   k_dim       element count and B stride, captured with start
//   addr_a      current A element address
//   addr_b      current B element address
//   addr_valid  address pair valid
//   addr_ready  consumer accepts pair when addr_valid && addr_ready
//   last        current pair is element K-1 (qualified by addr_valid)
//   busy        sequence in progress (RUN or DONE)
//   done        one-cycle pulse after the final pair is accepted
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | presenting address pairs, advancing on each handshake
// DONE   | one-cycle completion pulse, then back to IDLE

module dot_addr_seq #(
   parameter int AW = 16,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] base_a,
   input  logic [AW-1:0] base_b,
   input  logic [CW-1:0] k_dim,
   output logic [AW-1:0] addr_a,
   output logic [AW-1:0] addr_b,
   output logic          addr_valid,
   input  logic          addr_ready,
   output logic          last,
   output logic          busy,
   output logic          done
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] count;
   logic [CW-1:0] k_lat;
   logic [AW-1:0] stride;
   logic          at_last;
   logic          handshake;

   // Compare against the latched K so later k_dim changes cannot disturb
   // a running sequence.
   assign at_last   = (count == (k_lat - CW'(1)));
   assign handshake = (state == S_RUN) && addr_ready;
   assign stride    = AW'(k_lat);

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         addr_a <= '0;
         addr_b <= '0;
         count  <= '0;
         k_lat  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (k_dim != '0) begin
                     k_lat  <= k_dim;
                     addr_a <= base_a;
                     addr_b <= base_b;
                     count  <= '0;
                     state  <= S_RUN;
                  end else begin
                     state  <= S_DONE;
                  end
               end
            end
            S_RUN: begin
               if (handshake) begin
                  if (at_last) begin
                     // Final pair stays on the address lines.
                     state <= S_DONE;
                  end else begin
                     addr_a <= addr_a + AW'(1);
                     addr_b <= addr_b + stride;
                     count  <= count + CW'(1);
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign addr_valid = (state == S_RUN);
   assign last       = (state == S_RUN) && at_last;
   assign busy       = (state == S_RUN) || (state == S_DONE);
   assign done       = (state == S_DONE);

endmodule

// File: tb/tb_dot_addr_seq.sv
// tb_dot_addr_seq: self-checking bench for dot_addr_seq. A queue-based model
// holds the pairs still to be issued; a compare process checks every output
// on every falling edge, and directed tests pin the model with literal values.

module tb_dot_addr_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] base_a;
   logic [15:0] base_b;
   logic [15:0] k_dim;
   logic [15:0] addr_a;
   logic [15:0] addr_b;
   logic        addr_valid;
   logic        addr_ready;
   logic        last;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   dot_addr_seq #(.AW(16), .CW(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .base_a     (base_a),
      .base_b     (base_b),
      .k_dim      (k_dim),
      .addr_a     (addr_a),
      .addr_b     (addr_b),
      .addr_valid (addr_valid),
      .addr_ready (addr_ready),
      .last       (last),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [15:0] q_a[$];
   logic [15:0] q_b[$];
   logic        m_done = 1'b0;
   logic [15:0] h_a = '0;
   logic [15:0] h_b = '0;

   always @(posedge clk) begin
      if (reset) begin
         q_a.delete();
         q_b.delete();
         m_done = 1'b0;
         h_a    = '0;
         h_b    = '0;
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (q_a.size() != 0) begin
         if (addr_ready) begin
            void'(q_a.pop_front());
            void'(q_b.pop_front());
            if (q_a.size() == 0) m_done = 1'b1;
            else begin
               h_a = q_a[0];
               h_b = q_b[0];
            end
         end
      end else if (start) begin
         if (k_dim == 0) m_done = 1'b1;
         else begin
            for (int i = 0; i < int'(k_dim); i++) begin
               q_a.push_back(16'(int'(base_a) + i));
               q_b.push_back(16'(int'(base_b) + i * int'(k_dim)));
            end
            h_a = base_a;
            h_b = base_b;
         end
      end
   end

   // ---------------- comparison ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   logic        chk_en = 1'b0;
   logic [15:0] acc_a[$];
   logic [15:0] acc_b[$];
   logic        acc_last[$];
   int          busy_cnt = 0;
   int          done_cnt = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         logic e_valid;
         e_valid = (q_a.size() != 0);
         chk("addr_valid", 32'(addr_valid), 32'(e_valid));
         chk("busy", 32'(busy), 32'(e_valid || m_done));
         chk("done", 32'(done), 32'(m_done));
         chk("last", 32'(last), 32'(e_valid && q_a.size() == 1));
         chk("addr_a", 32'(addr_a), 32'(h_a));
         chk("addr_b", 32'(addr_b), 32'(h_b));
         if (addr_valid && addr_ready) begin
            acc_a.push_back(addr_a);
            acc_b.push_back(addr_b);
            acc_last.push_back(last);
         end
         if (busy) busy_cnt++;
         if (done) done_cnt++;
      end
   end

   // ---------------- stimulus helpers ----------------
   logic pat[7];
   int   pat_idx;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      acc_a.delete();
      acc_b.delete();
      acc_last.delete();
      busy_cnt = 0;
      done_cnt = 0;
   endtask

   task automatic do_start(input logic [15:0] a, input logic [15:0] b, input logic [15:0] k);
      base_a = a;
      base_b = b;
      k_dim  = k;
      start  = 1'b1;
      tick();
      start  = 1'b0;
   endtask

   // mode 0: ready always 1; 1: fixed pattern then 1; 2: random
   task automatic drain(input int mode, input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         if (mode == 1) begin
            addr_ready = (pat_idx < 7) ? pat[pat_idx] : 1'b1;
            pat_idx++;
         end else if (mode == 2) addr_ready = ($urandom_range(0, 2) != 0);
         else addr_ready = 1'b1;
         tick();
         n++;
      end
      chk("drain_timeout", 32'(busy), 32'(0));
      addr_ready = 1'b1;
      tick();
   endtask

   // ---------------- tests ----------------
   initial begin
      logic [15:0] ea[4];
      logic [15:0] eb[4];
      logic [15:0] wa[3];
      logic [15:0] wb[3];
      int n;

      reset = 1'b1; start = 1'b0; base_a = '0; base_b = '0; k_dim = '0; addr_ready = 1'b1;
      tick();
      tick();
      chk_en = 1'b1;
      chk("rst_addr_valid", 32'(addr_valid), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_addr_a", 32'(addr_a), 32'(0));
      reset = 1'b0;
      tick();

      // basic, ready always 1
      ea = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
      eb = '{16'h0200, 16'h0204, 16'h0208, 16'h020C};
      clear_log();
      addr_ready = 1'b1;
      do_start(16'h0010, 16'h0200, 16'd4);
      drain(0, 20);
      chk("basic_count", 32'(acc_a.size()), 32'd4);
      for (int i = 0; i < 4 && i < acc_a.size(); i++) begin
         chk("basic_a", 32'(acc_a[i]), 32'(ea[i]));
         chk("basic_b", 32'(acc_b[i]), 32'(eb[i]));
         chk("basic_last", 32'(acc_last[i]), 32'(i == 3));
      end
      chk("basic_busy_cycles", 32'(busy_cnt), 32'd5);
      chk("basic_done_pulses", 32'(done_cnt), 32'd1);

      // backpressure
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      pat_idx = 0;
      clear_log();
      addr_ready = pat[0];
      pat_idx = 1;
      do_start(16'h0010, 16'h0200, 16'd4);
      drain(1, 30);
      chk("bp_count", 32'(acc_a.size()), 32'd4);
      for (int i = 0; i < 4 && i < acc_a.size(); i++) begin
         chk("bp_a", 32'(acc_a[i]), 32'(ea[i]));
         chk("bp_b", 32'(acc_b[i]), 32'(eb[i]));
      end
      chk("bp_done_pulses", 32'(done_cnt), 32'd1);

      // wrap-around
      wa = '{16'hFFFF, 16'h0000, 16'h0001};
      wb = '{16'hFFF0, 16'hFFF3, 16'hFFF6};
      clear_log();
      do_start(16'hFFFF, 16'hFFF0, 16'd3);
      drain(0, 20);
      chk("wrap_count", 32'(acc_a.size()), 32'd3);
      for (int i = 0; i < 3 && i < acc_a.size(); i++) begin
         chk("wrap_a", 32'(acc_a[i]), 32'(wa[i]));
         chk("wrap_b", 32'(acc_b[i]), 32'(wb[i]));
      end

      // zero length
      clear_log();
      do_start(16'h1234, 16'h5678, 16'd0);
      chk("k0_done_after_start", 32'(done), 32'd1);
      drain(0, 10);
      chk("k0_pairs", 32'(acc_a.size()), 32'd0);
      chk("k0_done_pulses", 32'(done_cnt), 32'd1);
      chk("k0_busy_cycles", 32'(busy_cnt), 32'd1);

      // length one
      clear_log();
      do_start(16'd5, 16'd9, 16'd1);
      drain(0, 10);
      chk("k1_count", 32'(acc_a.size()), 32'd1);
      if (acc_a.size() == 1) begin
         chk("k1_a", 32'(acc_a[0]), 32'd5);
         chk("k1_b", 32'(acc_b[0]), 32'd9);
         chk("k1_last", 32'(acc_last[0]), 32'd1);
      end
      chk("k1_done_pulses", 32'(done_cnt), 32'd1);

      // start and k_dim change mid-run are ignored
      clear_log();
      do_start(16'h0100, 16'h1000, 16'd100);
      for (int i = 0; i < 10; i++) tick();
      k_dim = 16'd7; base_a = 16'hAAAA; base_b = 16'h5555; start = 1'b1;
      tick();
      start = 1'b0;
      drain(0, 200);
      chk("ign_count", 32'(acc_a.size()), 32'd100);
      if (acc_a.size() == 100) begin
         chk("ign_a99", 32'(acc_a[99]), 32'h0163);
         chk("ign_b1", 32'(acc_b[1]), 32'h1064);
         chk("ign_b99", 32'(acc_b[99]), 32'h36AC);
      end
      chk("ign_done_pulses", 32'(done_cnt), 32'd1);

      // reset mid-operation
      clear_log();
      do_start(16'h0020, 16'h0300, 16'd8);
      n = 0;
      while (acc_a.size() < 3 && n < 20) begin
         tick();
         n++;
      end
      chk("rst_mid_reached", 32'(acc_a.size() >= 3), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_mid_valid", 32'(addr_valid), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_addr_a", 32'(addr_a), 32'd0);
      chk("rst_mid_addr_b", 32'(addr_b), 32'd0);
      tick();
      tick();
      chk("rst_mid_no_done", 32'(done_cnt), 32'd0);
      clear_log();
      do_start(16'd7, 16'd8, 16'd2);
      drain(0, 10);
      chk("rst_restart_count", 32'(acc_a.size()), 32'd2);
      if (acc_a.size() == 2) begin
         chk("rst_restart_a1", 32'(acc_a[1]), 32'd8);
         chk("rst_restart_b1", 32'(acc_b[1]), 32'd10);
      end

      // random traffic checked cycle by cycle against the model
      for (int i = 0; i < 2000; i++) begin
         start      = ($urandom_range(0, 5) == 0);
         base_a     = 16'($urandom);
         base_b     = 16'($urandom);
         k_dim      = 16'($urandom_range(0, 12));
         addr_ready = ($urandom_range(0, 2) != 0);
         reset      = ($urandom_range(0, 149) == 0);
         tick();
      end
      start = 1'b0;
      reset = 1'b0;
      drain(0, 50);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
